// File: rtl/filt_oup_quant_pkg.sv
// Shared arithmetic helpers for the filt_* output stages: rounding, saturation
// and the decimation phase-counter width.
package filt_pkg;

    localparam int FILT_CALC_W = 64;

    typedef logic signed [FILT_CALC_W-1:0] filt_calc_t;

    // A counter for n phases needs at least one bit, even when n is 1.
    function automatic int f_phase_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic filt_calc_t f_rnd(input filt_calc_t value, input int frac, input bit mode);
        filt_calc_t v;
        v = value;
        if (mode && (frac > 0)) begin
            v = v + (filt_calc_t'(1) <<< (frac - 1));
        end
        return v >>> frac;
    endfunction

    function automatic filt_calc_t f_sat(input filt_calc_t value, input int width);
        filt_calc_t hi;
        filt_calc_t lo;
        hi = (filt_calc_t'(1) <<< (width - 1)) - filt_calc_t'(1);
        lo = -(filt_calc_t'(1) <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/filt_oup_quant_sat.sv
// Combinational signed saturator with a clip indication; shared by filt_* outputs.
module filt_sat
    import filt_pkg::*;
#(
    parameter int gp_inp_width = 17,
    parameter int gp_oup_width = 16
) (
    input  logic signed [gp_inp_width-1:0] i_data,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_clip
);

    filt_calc_t ext;
    filt_calc_t sat;

    always_comb begin
        ext    = filt_calc_t'(i_data);
        sat    = f_sat(ext, gp_oup_width);
        o_data = gp_oup_width'(sat);
        o_clip = (sat != ext);
    end

endmodule

// File: rtl/filt_oup_quant.sv
// Output stage after filt_mac: strobe edge detect, decimation, round then
// saturate over two pipeline stages, with a sticky clip flag.
module filt_oup_quant
    import filt_pkg::*;
#(
    parameter int gp_inp_width  = 24,
    parameter int gp_oup_width  = 16,
    parameter int gp_frac_bits  = 8,
    parameter int gp_dec_factor = 1,
    parameter int gp_rnd_mode   = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic signed [gp_inp_width-1:0] i_data,
    input  logic                           i_done,
    input  logic                           i_sat_clr,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_valid,
    output logic                           o_sat
);

    localparam int R1_W = gp_inp_width + 1 - gp_frac_bits;
    localparam int PH_W = f_phase_w(gp_dec_factor);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(gp_dec_factor - 1);

    if (gp_inp_width - gp_frac_bits < gp_oup_width) begin : g_bad_width
        $error("filt_oup_quant: gp_inp_width - gp_frac_bits must be >= gp_oup_width");
    end
    if (gp_dec_factor < 1) begin : g_bad_dec
        $error("filt_oup_quant: gp_dec_factor must be >= 1");
    end

    logic                           done_q;
    logic [PH_W-1:0]                phase_q;
    logic [PH_W-1:0]                phase_d;
    logic                           stb;
    logic                           accept;
    logic signed [R1_W-1:0]         r1_d;
    logic signed [R1_W-1:0]         r1_p1_q;
    logic                           vld_p1_q;
    logic signed [gp_oup_width-1:0] sat_data;
    logic                           sat_clip;
    logic signed [gp_oup_width-1:0] o_data_q;
    logic                           o_valid_q;
    logic                           o_sat_q;
    logic                           o_sat_d;

    always_comb begin
        stb     = i_done & ~done_q & i_ena;
        accept  = stb & (phase_q == '0);
        phase_d = phase_q;
        if (stb) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
        // One extra MSB keeps the +half add from wrapping at full scale.
        r1_d    = R1_W'(f_rnd(filt_calc_t'(i_data), gp_frac_bits, gp_rnd_mode != 0));
        // A clip in the same cycle as a clear wins.
        o_sat_d = (vld_p1_q & sat_clip) | (o_sat_q & ~i_sat_clr);
    end

    filt_sat #(
        .gp_inp_width(R1_W),
        .gp_oup_width(gp_oup_width)
    ) u_sat (
        .i_data(r1_p1_q),
        .o_data(sat_data),
        .o_clip(sat_clip)
    );

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            done_q    <= 1'b0;
            phase_q   <= '0;
            vld_p1_q  <= 1'b0;
            o_valid_q <= 1'b0;
            o_sat_q   <= 1'b0;
            o_data_q  <= '0;
        end else begin
            done_q    <= i_done;
            phase_q   <= phase_d;
            // stage 1 -> stage 2 boundary
            vld_p1_q  <= accept;
            o_valid_q <= vld_p1_q;
            o_sat_q   <= o_sat_d;
            if (vld_p1_q) begin
                o_data_q <= sat_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            r1_p1_q <= r1_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_sat   = o_sat_q;

endmodule
